ip_seq_ctrl: RTL
================

# ip_seq_ctrl

Instruction-pointer sequencer for the bus interface unit. It generates the `ld`/`inc`/`isr`/`oe` strobes for the 32-bit IP register and runs the fetch handshake with memory. It arbitrates between interrupt entry, branch loads and sequential fetches. It sits between the execution unit's control requests and the IP register, memory read port and instruction-register load.

## Interface
Parameters:
- TIMEOUT, 15, max FETCH cycles without `mem_ack` before a bus error (≥2)
- CW, 4, width of timeout counter (2^CW > TIMEOUT)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- fetch_req  in  1  EU requests next instruction word; level, held until `ir_ld`
- br_req  in  1  EU requests IP load from shared bus (target driven by EU); level, held until `ip_ld`
- intr  in  1  external interrupt request; level, held until `intr_ack`
- iret  in  1  one-cycle pulse: return from ISR complete, clears `in_isr`
- mem_ack  in  1  memory has valid instruction word on bus this cycle
- ip_ld / ip_inc / ip_isr  out  1  IP register controls (load bus / +1 / load vector 0x3FF)
- ip_oe  out  1  IP register drives address/data bus
- mem_rd  out  1  memory read strobe
- ir_ld  out  1  instruction register load strobe
- save_ip  out  1  push strobe: stack logic captures IP from bus
- intr_ack  out  1  interrupt accepted
- in_isr  out  1  servicing interrupt; masks further `intr`
- bus_err  out  1  one-cycle fetch timeout pulse
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, FETCH, INC, BRANCH, SAVE, VECT, ERR.
- IDLE arbitration, sampled each cycle, fixed priority:
  - `intr & ~in_isr` → SAVE.
  - else `br_req` → BRANCH.
  - else `fetch_req` → FETCH.
  - else stay in IDLE.
- FETCH:
  - `ip_oe=1` and `mem_rd=1` every cycle; counter increments each cycle without `mem_ack`.
  - `mem_ack` → `ir_ld=1` in the same cycle (Mealy), next state INC.
  - Counter reaches TIMEOUT with no ack → ERR.
  - `mem_ack` in the final counted cycle wins over the timeout.
- INC: `ip_inc=1` for one cycle → IDLE.
- BRANCH: `ip_ld=1` for one cycle, `ip_oe=0` → IDLE.
- SAVE: `ip_oe=1`, `save_ip=1` for one cycle → VECT.
- VECT: `ip_isr=1`, `intr_ack=1` for one cycle; sets `in_isr` at exit edge → IDLE.
- ERR: `bus_err=1` for one cycle, IP unchanged → IDLE. The pending `fetch_req` is retried by normal arbitration.
- `in_isr` is cleared by `iret` at any state's clock edge. If `iret` and `intr` are both high in IDLE, the interrupt is not taken that cycle; it is taken in the next cycle if `intr` is still high.
- Invariants:
  - At most one of `ip_ld`/`ip_inc`/`ip_isr` is high in any cycle.
  - `ip_oe` and `ip_ld` are never high together.
  - `mem_rd` is high only in FETCH.
- Counter clears on FETCH entry.
- Requests arriving while `busy=1` are ignored until IDLE; no queuing.

## Timing
- Reset (async): state IDLE, counter 0, `in_isr=0`, all outputs 0 — immediate, including mid-fetch.
- Outputs are decoded from registered state; the only Mealy term is `ir_ld`.
- Fetch with zero-wait memory: request seen in IDLE at edge k; FETCH in cycle k+1 (`mem_ack` → `ir_ld`); INC in cycle k+2; IDLE in cycle k+3. Back-to-back fetches therefore take 3 cycles each.
- Each memory wait cycle adds 1 cycle. A timeout gives TIMEOUT FETCH cycles followed by 1 ERR cycle.
- Branch: 2 cycles (IDLE→BRANCH→IDLE).
- Interrupt entry: 3 cycles (IDLE→SAVE→VECT→IDLE); `in_isr` is high from the cycle after VECT.

## Test plan
- Reset, then `fetch_req` held with `mem_ack` on the 1st FETCH cycle → `ir_ld` and `ip_inc` pulses at a 3-cycle period; IP increments 0→1→2.
- `mem_ack` delayed 4 cycles → `mem_rd`/`ip_oe` high for 5 cycles, one `ir_ld`, one `ip_inc`, no `bus_err`.
- No `mem_ack` for 15 cycles (TIMEOUT=15) → `bus_err` one cycle, no `ip_inc`, refetch starts with `mem_rd` high again.
- `intr`, `br_req` and `fetch_req` all asserted in IDLE → SAVE (`save_ip` with `ip_oe`), VECT (`ip_isr`, `intr_ack`), IP=0x3FF, `in_isr=1`. Then BRANCH executes, then FETCH. A second `intr` is ignored until `iret`.
- Reset asserted mid-FETCH (cycle 2 of wait) → all outputs 0 immediately, `in_isr=0`. After release, IDLE arbitration resumes.
- Strobe invariants checked every cycle throughout: `ip_ld`/`ip_inc`/`ip_isr` one-hot-or-zero, `ip_oe & ip_ld` never high together.

Source files
------------

// File: rtl/ip_seq_ctrl.sv
// ip_seq_ctrl - instruction-pointer sequencer for the bus interface unit.
// Arbitrates interrupt entry, branch loads and sequential fetches, and
// drives the IP register strobes and the memory fetch handshake.
//
// Ports:
//   Clk, Reset      clock (rising edge), asynchronous active-high reset
//   fetch_req       EU wants the next instruction word (level)
//   br_req          EU wants IP loaded from the shared bus (level)
//   intr            external interrupt request (level)
//   iret            one-cycle pulse, leaves the interrupt service routine
//   mem_ack         memory has the instruction word on the bus
//   ip_ld/ip_inc/ip_isr  IP register: load bus / increment / load vector
//   ip_oe           IP register drives the bus
//   mem_rd, ir_ld   memory read strobe, instruction register load
//   save_ip         stack logic captures IP from the bus
//   intr_ack        interrupt accepted
//   in_isr          interrupt being serviced, masks intr
//   bus_err         one-cycle fetch timeout pulse
//   busy            sequencer not idle
module ip_seq_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic fetch_req,
  input  logic br_req,
  input  logic intr,
  input  logic iret,
  input  logic mem_ack,
  output logic ip_ld,
  output logic ip_inc,
  output logic ip_isr,
  output logic ip_oe,
  output logic mem_rd,
  output logic ir_ld,
  output logic save_ip,
  output logic intr_ack,
  output logic in_isr,
  output logic bus_err,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE, FETCH, INC, BRANCH, SAVE, VECT, ERR
  } state_t;

  // Value of the wait counter during the last allowed FETCH cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      in_isr <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      // Set on leaving VECT, cleared by iret from any state.
      in_isr <= (in_isr & ~iret) | (state == VECT);
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ip_ld    = 1'b0;
    ip_inc   = 1'b0;
    ip_isr   = 1'b0;
    ip_oe    = 1'b0;
    mem_rd   = 1'b0;
    ir_ld    = 1'b0;
    save_ip  = 1'b0;
    intr_ack = 1'b0;
    bus_err  = 1'b0;

    unique case (state)
      IDLE: begin
        // An iret in the same cycle defers interrupt entry by one cycle.
        if (intr && !in_isr && !iret) begin
          state_n = SAVE;
        end else if (br_req) begin
          state_n = BRANCH;
        end else if (fetch_req) begin
          state_n = FETCH;
          cnt_n   = '0;
        end
      end
      FETCH: begin
        ip_oe  = 1'b1;
        mem_rd = 1'b1;
        // Ack is checked before the timeout so a late ack still wins.
        if (mem_ack) begin
          ir_ld   = 1'b1;
          state_n = INC;
        end else if (cnt == CNT_LAST) begin
          state_n = ERR;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      INC: begin
        ip_inc  = 1'b1;
        state_n = IDLE;
      end
      BRANCH: begin
        ip_ld   = 1'b1;
        state_n = IDLE;
      end
      SAVE: begin
        ip_oe   = 1'b1;
        save_ip = 1'b1;
        state_n = VECT;
      end
      VECT: begin
        ip_isr   = 1'b1;
        intr_ack = 1'b1;
        state_n  = IDLE;
      end
      ERR: begin
        bus_err = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
